// File: rtl/operand_collector.sv
// Operand collector: selects, forwards and registers two ALU operands.
// Single-entry skid-free output register with a load-use hazard stall.
module operand_collector #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int FWD_CH      = 2,
  parameter int LINK_OFFSET = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_pc,
  input  logic [15:0]              in_imm,
  input  logic [1:0]               in_sel1,
  input  logic [2:0]               in_sel2,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [DATA_W-1:0]        rf_data_1,
  input  logic [DATA_W-1:0]        rf_data_2,
  input  logic [DATA_W-1:0]        cp_read_data,
  input  logic [FWD_CH-1:0]        fwd_valid,
  input  logic [FWD_CH-1:0]        fwd_pending,
  input  logic [FWD_CH*5-1:0]      fwd_addr,
  input  logic [FWD_CH*DATA_W-1:0] fwd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        operand_1,
  output logic [DATA_W-1:0]        operand_2,
  output logic [15:0]              stall_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state;
  logic [DATA_W:0]   res1;
  logic [DATA_W:0]   res2;
  logic              use1;
  logic              use2;
  logic              hazard;
  logic              accept;
  logic [ADDR_W-1:0] link_pc;
  logic [DATA_W-1:0] nxt1;
  logic [DATA_W-1:0] nxt2;

  // Returns {pending, data}; lowest-index match wins, r0 is hardwired zero.
  function automatic logic [DATA_W:0] resolve(
    input logic [4:0]        r,
    input logic [DATA_W-1:0] rf
  );
    logic [DATA_W:0] res;
    res = {1'b0, rf};
    for (int i = FWD_CH - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_addr[5*i +: 5] == r)
        res = {fwd_pending[i], fwd_data[DATA_W*i +: DATA_W]};
    end
    if (r == 5'd0)
      res = '0;
    return res;
  endfunction

  assign res1    = resolve(in_rs, rf_data_1);
  assign res2    = resolve(in_rt, rf_data_2);
  assign use1    = (in_sel1 == 2'd0) && (in_rs != 5'd0);
  assign use2    = (in_sel2 == 3'd0) && (in_rt != 5'd0);
  assign hazard  = (use1 && res1[DATA_W]) || (use2 && res2[DATA_W]);
  assign in_ready  = !hazard && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == FULL);
  assign link_pc   = in_pc + ADDR_W'(LINK_OFFSET);

  always_comb begin
    nxt1 = '0;
    case (in_sel1)
      2'd0:    nxt1 = res1[DATA_W-1:0];
      2'd1:    nxt1 = DATA_W'(link_pc);
      2'd2:    nxt1 = cp_read_data;
      default: nxt1 = '0;
    endcase
  end

  always_comb begin
    nxt2 = '0;
    case (in_sel2)
      3'd0:    nxt2 = res2[DATA_W-1:0];
      3'd1:    nxt2 = {{(DATA_W-16){in_imm[15]}}, in_imm};
      3'd2:    nxt2 = DATA_W'(in_imm);
      3'd3:    nxt2 = DATA_W'({in_imm, 16'h0000});
      default: nxt2 = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      operand_1   <= '0;
      operand_2   <= '0;
      stall_count <= '0;
    end else begin
      if (in_valid && hazard && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
      if (accept) begin
        operand_1 <= nxt1;
        operand_2 <= nxt2;
        state     <= FULL;
      end else if (out_ready) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_operand_collector.sv
// Bench for operand_collector: directed cases plus random traffic,
// checked by a posedge reference model feeding a negedge monitor.
module tb_operand_collector;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_pc;
  logic [15:0]     in_imm;
  logic [1:0]      in_sel1;
  logic [2:0]      in_sel2;
  logic [4:0]      in_rs;
  logic [4:0]      in_rt;
  logic [DW-1:0]   rf_data_1;
  logic [DW-1:0]   rf_data_2;
  logic [DW-1:0]   cp_read_data;
  logic [CH-1:0]   fwd_valid;
  logic [CH-1:0]   fwd_pending;
  logic [CH*5-1:0] fwd_addr;
  logic [CH*DW-1:0] fwd_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   operand_1;
  logic [DW-1:0]   operand_2;
  logic [15:0]     stall_count;

  int vectors = 0;
  int errors  = 0;

  logic [2*DW-1:0] q[$];
  logic            m_full  = 1'b0;
  logic [15:0]     m_stall = '0;

  operand_collector #(
    .DATA_W(DW), .ADDR_W(AW), .FWD_CH(CH), .LINK_OFFSET(8)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_sel1(in_sel1), .in_sel2(in_sel2),
    .in_rs(in_rs), .in_rt(in_rt),
    .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
    .cp_read_data(cp_read_data),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .operand_1(operand_1), .operand_2(operand_2),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Register read as the architecture sees it: first matching channel wins.
  function automatic logic [DW-1:0] ref_reg(input logic [4:0] r,
                                            input logic [DW-1:0] rf);
    if (r == 0) return '0;
    for (int i = 0; i < CH; i++)
      if (fwd_valid[i] && fwd_addr[5*i +: 5] == r)
        return fwd_data[DW*i +: DW];
    return rf;
  endfunction

  function automatic bit ref_wait(input logic [4:0] r, input bit used);
    if (!used || r == 0) return 0;
    for (int i = 0; i < CH; i++)
      if (fwd_valid[i] && fwd_addr[5*i +: 5] == r)
        return fwd_pending[i];
    return 0;
  endfunction

  function automatic bit ref_hazard();
    return ref_wait(in_rs, in_sel1 == 0) || ref_wait(in_rt, in_sel2 == 0);
  endfunction

  function automatic logic [DW-1:0] ref_op1();
    case (in_sel1)
      0: return ref_reg(in_rs, rf_data_1);
      1: return in_pc + 32'd8;
      2: return cp_read_data;
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] ref_op2();
    int signed s;
    case (in_sel2)
      0: return ref_reg(in_rt, rf_data_2);
      1: begin s = $signed(in_imm); return s; end
      2: return in_imm;
      3: return in_imm * 32'd65536;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: advances on the same edge the DUT does.
  always @(posedge clk) begin
    bit h;
    if (rst) begin
      q.delete();
      m_full  = 1'b0;
      m_stall = '0;
    end else begin
      h = ref_hazard();
      if (in_valid && h && m_stall != 16'hFFFF) m_stall++;
      if (in_valid && !h && (!m_full || out_ready)) begin
        q.push_back({ref_op1(), ref_op2()});
        m_full = 1'b1;
      end else if (out_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: compares handshake outputs and pops on completed transfers.
  always @(negedge clk) begin
    bit exp_ready;
    exp_ready = !ref_hazard() && (!m_full || out_ready);
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("out_valid", 64'(out_valid), 64'(m_full));
    chk("stall_count", 64'(stall_count), 64'(m_stall));
    if (out_valid) begin
      if (q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL scoreboard: out_valid with empty queue");
      end else begin
        chk("operands", {operand_1, operand_2}, q[0]);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    in_valid = 0; in_pc = '0; in_imm = '0;
    in_sel1 = 0; in_sel2 = 0; in_rs = 0; in_rt = 0;
    rf_data_1 = '0; rf_data_2 = '0; cp_read_data = '0;
    fwd_valid = '0; fwd_pending = '0; fwd_addr = '0; fwd_data = '0;
  endtask

  task automatic rand_in();
    in_valid = ($urandom_range(0, 3) != 0);
    in_pc = $urandom;
    in_imm = 16'($urandom);
    in_sel1 = ($urandom_range(0, 1) != 0) ? 2'd0 : 2'($urandom);
    in_sel2 = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'($urandom);
    in_rs = 5'($urandom_range(0, 3));
    in_rt = 5'($urandom_range(0, 3));
    rf_data_1 = $urandom; rf_data_2 = $urandom; cp_read_data = $urandom;
    for (int i = 0; i < CH; i++) begin
      fwd_valid[i] = $urandom_range(0, 1) != 0;
      fwd_pending[i] = $urandom_range(0, 3) == 0;
      fwd_addr[5*i +: 5] = 5'($urandom_range(0, 3));
      fwd_data[DW*i +: DW] = $urandom;
    end
    out_ready = $urandom_range(0, 3) != 0;
  endtask

  initial begin
    clr();
    rst = 1; out_ready = 1;
    tick(); tick();
    rst = 0;
    @(negedge clk);
    chk("reset op1", 64'(operand_1), 64'h0);
    chk("reset op2", 64'(operand_2), 64'h0);
    chk("reset stall", 64'(stall_count), 64'h0);

    // load-use stall on ch0 for three cycles
    tick();
    in_valid = 1; in_sel1 = 0; in_rs = 5; in_sel2 = 4;
    fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd5}; fwd_pending = 2'b01;
    repeat (3) begin
      @(negedge clk);
      chk("stall in_ready", 64'(in_ready), 64'h0);
      tick();
    end
    fwd_pending = 2'b00; fwd_data = {32'h0, 32'h77};
    tick();
    clr();
    @(negedge clk);
    chk("stall op1", 64'(operand_1), 64'h77);
    chk("stall count", 64'(stall_count), 64'd3);

    tick();
    in_valid = 1; in_sel1 = 1; in_pc = 32'h0040_0010;
    in_sel2 = 3; in_imm = 16'h1234;
    tick();
    in_valid = 0;
    @(negedge clk);
    chk("link op1", 64'(operand_1), 64'h0040_0018);
    chk("lui op2", 64'(operand_2), 64'h1234_0000);
    chk("link valid", 64'(out_valid), 64'h1);

    tick();
    in_valid = 1; in_sel2 = 1; in_imm = 16'h8000;
    tick();
    in_sel2 = 2;
    @(negedge clk);
    chk("sext op2", 64'(operand_2), 64'hFFFF_8000);
    tick();
    in_valid = 0;
    @(negedge clk);
    chk("zext op2", 64'(operand_2), 64'h0000_8000);

    tick();
    clr();
    in_valid = 1; in_sel1 = 0; in_rs = 5; rf_data_1 = 32'h11;
    fwd_valid = 2'b11; fwd_addr = {5'd5, 5'd5};
    fwd_data = {32'hBB, 32'hAA}; fwd_pending = 2'b00;
    tick();
    clr();
    @(negedge clk);
    chk("fwd priority", 64'(operand_1), 64'hAA);

    in_valid = 1; in_sel1 = 0; in_rs = 0;
    fwd_valid = 2'b01; fwd_addr = '0; fwd_pending = 2'b01;
    fwd_data = {32'h0, 32'hDEAD};
    @(negedge clk);
    chk("r0 ready", 64'(in_ready), 64'h1);
    tick();
    clr();
    @(negedge clk);
    chk("r0 op1", 64'(operand_1), 64'h0);
    chk("r0 stall", 64'(stall_count), 64'd3);

    // back-pressure hold, then no-bubble reload, then reset
    in_valid = 1; in_sel1 = 2; cp_read_data = 32'hCAFE_0001;
    tick();
    out_ready = 0; cp_read_data = 32'hCAFE_0002;
    repeat (2) begin
      @(negedge clk);
      chk("hold op1", 64'(operand_1), 64'hCAFE_0001);
      chk("hold ready", 64'(in_ready), 64'h0);
      tick();
    end
    out_ready = 1;
    tick();
    in_valid = 0; out_ready = 0;
    @(negedge clk);
    chk("reload op1", 64'(operand_1), 64'hCAFE_0002);
    chk("reload valid", 64'(out_valid), 64'h1);
    rst = 1;
    tick();
    rst = 0; out_ready = 1;
    @(negedge clk);
    chk("rst valid", 64'(out_valid), 64'h0);
    chk("rst op1", 64'(operand_1), 64'h0);

    for (int n = 0; n < 800; n++) begin
      rand_in();
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    clr();
    rst = 0; out_ready = 1;
    tick(); tick();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
